// File: rtl/gf2mz_mult_sched.sv
// Round-robin scheduler sharing one GF(2^m)[z] multiplier core among NREQ requesters.
// Optional performance counters are enabled with `define GF2MZ_SCHED_PERF_EN.
module gf2mz_mult_sched #(
  parameter int NREQ    = 2,
  parameter int SEL_W   = 1,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  ack,
  output logic             err,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] core_sel,
  output logic             core_start,
  input  logic             core_done,
  output logic             busy
`ifdef GF2MZ_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_ops,
  output logic [CNT_W-1:0] perf_busy_cyc
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    ACK
  } state_t;

  localparam logic             WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] cand;
  logic [NREQ-1:0]  pick_grant;
  logic             pick_valid;

  // Scan offsets from farthest to nearest so the requester closest after 'last' wins.
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = SEL_W'((int'(last) + i) % NREQ);
      if (req[cand]) pick_idx = cand;
    end
  end

  assign pick_valid = |req;
  assign pick_grant = NREQ'(1) << pick_idx;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      ack        <= '0;
      err        <= 1'b0;
      grant      <= '0;
      core_sel   <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      wd_cnt     <= '0;
      last       <= SEL_W'(NREQ - 1);
    end else begin
      ack        <= '0;
      err        <= 1'b0;
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= START;
            grant      <= pick_grant;
            core_sel   <= pick_idx;
            core_start <= 1'b1;
            busy       <= 1'b1;
            last       <= pick_idx;
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          // A real completion takes precedence over a watchdog expiry in the same cycle.
          if (core_done) begin
            state <= ACK;
            ack   <= grant;
          end else if (WD_EN && wd_cnt == WD_LAST) begin
            state <= ACK;
            ack   <= grant;
            err   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ACK: begin
          state  <= IDLE;
          grant  <= '0;
          busy   <= 1'b0;
          wd_cnt <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef GF2MZ_SCHED_PERF_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      perf_ops      <= '0;
      perf_busy_cyc <= '0;
    end else begin
      if (|ack && perf_ops != '1) perf_ops <= perf_ops + 1'b1;
      if (busy && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gf2mz_mult_sched.sv
// Self-checking bench for gf2mz_mult_sched: a long-timeout and a short-timeout instance
// share stimulus; the observed instance is selected by use_t.
module tb_gf2mz_mult_sched;

  localparam int NREQ  = 2;
  localparam int SEL_W = 1;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b;
  logic [NREQ-1:0] req;
  logic core_done;
  logic use_t;

  logic [NREQ-1:0] ack_m, grant_m, ack_t, grant_t;
  logic err_m, err_t, start_m, start_t, busy_m, busy_t;
  logic [SEL_W-1:0] sel_m, sel_t;
`ifdef GF2MZ_SCHED_PERF_EN
  logic [CNT_W-1:0] perf_ops, perf_busy_cyc, perf_ops_t, perf_busy_t;
`endif

  logic [NREQ-1:0] ack, grant;
  logic err, core_start, busy;
  logic [SEL_W-1:0] core_sel;

  int checks = 0;
  int fails = 0;
  int start_cnt = 0;
  int multi_grant = 0;
  exp_t exp_q[$];
  logic [NREQ-1:0] obs_ack;
  logic obs_err;

  gf2mz_mult_sched #(.NREQ(NREQ), .SEL_W(SEL_W), .TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .ack(ack_m), .err(err_m), .grant(grant_m),
    .core_sel(sel_m), .core_start(start_m), .core_done(core_done), .busy(busy_m)
`ifdef GF2MZ_SCHED_PERF_EN
    , .perf_ops(perf_ops), .perf_busy_cyc(perf_busy_cyc)
`endif
  );

  gf2mz_mult_sched #(.NREQ(NREQ), .SEL_W(SEL_W), .TIMEOUT(8), .CNT_W(CNT_W)) dut_t (
    .clk(clk), .rst_b(rst_b), .req(req), .ack(ack_t), .err(err_t), .grant(grant_t),
    .core_sel(sel_t), .core_start(start_t), .core_done(core_done), .busy(busy_t)
`ifdef GF2MZ_SCHED_PERF_EN
    , .perf_ops(perf_ops_t), .perf_busy_cyc(perf_busy_t)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    if (use_t) begin
      ack = ack_t; grant = grant_t; err = err_t;
      core_start = start_t; busy = busy_t; core_sel = sel_t;
    end else begin
      ack = ack_m; grant = grant_m; err = err_m;
      core_start = start_m; busy = busy_m; core_sel = sel_m;
    end
  end

  always @(negedge clk) begin
    if (rst_b && start_m) start_cnt++;
    if ($countones(grant_m) > 1 || $countones(grant_t) > 1) multi_grant++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0; req = '0; core_done = 1'b0;
    tick(); tick();
    rst_b = 1'b1;
    tick();
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (core_start) seen = 1'b1;
    end
  endtask

  // Starting just after the START edge, raise core_done so it is sampled on the lat-th edge.
  task automatic finish_op(input int lat, input bit send_done, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      core_done = send_done && (i == lat - 1);
      tick();
      core_done = 1'b0;
      if (ack !== '0) got = 1'b1;
    end
    obs_ack = ack;
    obs_err = err;
    if (got) req = req & ~ack;
  endtask

  task automatic check_pop(input string name, input bit got);
    exp_t e;
    e = exp_q.pop_front();
    checks++;
    if (!got || obs_ack !== e.ack || obs_err !== e.err) begin
      fails++;
      $display("[TB] FAIL %s: got ack=%b err=%b (seen=%0d), want ack=%b err=%b", name, obs_ack, obs_err, got, e.ack, e.err);
    end
  endtask

  task automatic test_reset();
    use_t = 1'b0; rst_b = 1'b0; req = 2'b11; core_done = 1'b0;
    tick(); tick();
    checks++;
    if ({ack_m, err_m, grant_m, sel_m, start_m, busy_m, ack_t, err_t, grant_t, sel_t, start_t, busy_t} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got grant=%b busy=%b start=%b ack=%b, want all zero", grant_m, busy_m, start_m, ack_m);
    end
`ifdef GF2MZ_SCHED_PERF_EN
    checks++;
    if (perf_ops !== '0 || perf_busy_cyc !== '0 || perf_ops_t !== '0 || perf_busy_t !== '0) begin
      fails++;
      $display("[TB] FAIL reset_perf: got ops=%0d busy_cyc=%0d, want 0 0", perf_ops, perf_busy_cyc);
    end
`endif
    req = '0;
    rst_b = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      fails++;
      $display("[TB] FAIL reset_idle: got busy=%b grant=%b, want 0 00", busy, grant);
    end
  endtask

  task automatic test_single();
    bit seen, got;
    int s0;
    exp_t e;
    s0 = start_cnt;
    req = 2'b01;
    e.ack = 2'b01; e.err = 1'b0; exp_q.push_back(e);
    wait_start(6, seen);
    checks++;
    if (!seen || grant !== 2'b01 || core_sel !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL single_grant: got seen=%0d grant=%b sel=%b busy=%b, want 1 01 0 1", seen, grant, core_sel, busy);
    end
    finish_op(20, 1'b1, 40, got);
    check_pop("single_ack", got);
    tick();
    checks++;
    if (grant !== '0 || ack !== '0 || err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_release: got grant=%b ack=%b err=%b busy=%b, want 00 00 0 0", grant, ack, err, busy);
    end
    checks++;
    if (start_cnt - s0 != 1) begin
      fails++;
      $display("[TB] FAIL single_start_count: got %0d, want 1", start_cnt - s0);
    end
  endtask

  task automatic test_contention();
    bit seen, got;
    int s0, mg0;
    exp_t e;
    logic [NREQ-1:0] want_g;
    do_reset();
    s0 = start_cnt; mg0 = multi_grant;
    req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      want_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      e.ack = want_g; e.err = 1'b0; exp_q.push_back(e);
      wait_start(6, seen);
      checks++;
      if (!seen || grant !== want_g || core_sel !== want_g[1]) begin
        fails++;
        $display("[TB] FAIL contention_grant%0d: got grant=%b sel=%b, want %b %b", n, grant, core_sel, want_g, want_g[1]);
      end
      finish_op(3 + n, 1'b1, 30, got);
      check_pop("contention_ack", got);
      tick();
      req = 2'b11;
    end
    req = '0;
    tick();
    checks++;
    if (start_cnt - s0 != 4 || multi_grant != mg0) begin
      fails++;
      $display("[TB] FAIL contention_onehot: got starts=%0d multi=%0d, want 4 0", start_cnt - s0, multi_grant - mg0);
    end
  endtask

  task automatic test_fairness();
    bit seen, got;
    exp_t e;
    do_reset();
    req = 2'b10;
    e.ack = 2'b10; e.err = 1'b0; exp_q.push_back(e);
    wait_start(6, seen);
    checks++;
    if (!seen || grant !== 2'b10 || core_sel !== 1'b1) begin
      fails++;
      $display("[TB] FAIL fair_lone: got grant=%b sel=%b, want 10 1", grant, core_sel);
    end
    finish_op(4, 1'b1, 20, got);
    check_pop("fair_lone_ack", got);
    tick();
    req = 2'b11;
    e.ack = 2'b01; exp_q.push_back(e);
    e.ack = 2'b10; exp_q.push_back(e);
    wait_start(6, seen);
    checks++;
    if (!seen || grant !== 2'b01) begin
      fails++;
      $display("[TB] FAIL fair_simul_first: got grant=%b, want 01", grant);
    end
    finish_op(4, 1'b1, 20, got);
    check_pop("fair_simul_ack0", got);
    tick();
    wait_start(6, seen);
    checks++;
    if (!seen || grant !== 2'b10) begin
      fails++;
      $display("[TB] FAIL fair_simul_second: got grant=%b, want 10", grant);
    end
    finish_op(4, 1'b1, 20, got);
    check_pop("fair_simul_ack1", got);
    tick();
  endtask

  task automatic test_spurious_done();
    bit seen, early;
    exp_t e;
    do_reset();
    use_t = 1'b1;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    checks++;
    if (ack !== '0 || busy !== 1'b0 || grant !== '0) begin
      fails++;
      $display("[TB] FAIL spurious_idle: got ack=%b busy=%b grant=%b, want 00 0 00", ack, busy, grant);
    end
    req = 2'b01;
    wait_start(6, seen);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checks++;
    if (!seen || ack !== '0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL spurious_start: got seen=%0d ack=%b busy=%b, want 1 00 1", seen, ack, busy);
    end
    early = 1'b0;
    repeat (7) begin
      tick();
      if (ack !== '0) early = 1'b1;
    end
    core_done = 1'b1;
    e.ack = 2'b01; e.err = 1'b0; exp_q.push_back(e);
    tick();
    core_done = 1'b0;
    obs_ack = ack; obs_err = err;
    check_pop("simul_done_timeout", !early);
    req = req & ~ack;
    tick();
    use_t = 1'b0;
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    exp_t e;
    use_t = 1'b1;
    req = 2'b01;
    e.ack = 2'b01; e.err = 1'b1; exp_q.push_back(e);
    wait_start(6, seen);
    tick();
    n = 0;
    while (ack === '0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!seen || n != 8) begin
      fails++;
      $display("[TB] FAIL timeout_latency: got %0d cycles (seen=%0d), want 8", n, seen);
    end
    obs_ack = ack; obs_err = err;
    check_pop("timeout_ack_err", n < 20);
    req = req & ~ack;
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== '0 || ack !== '0 || err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timeout_idle: got busy=%b grant=%b ack=%b err=%b, want 0 00 00 0", busy, grant, ack, err);
    end
    use_t = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    bit seen, got;
    exp_t e;
    logic [NREQ-1:0] want_g;
    use_t = 1'b0;
    do_reset();
    req = 2'b01;
    wait_start(6, seen);
    tick(); tick(); tick();
    rst_b = 1'b0;
    #1;
    checks++;
    if ({ack_m, err_m, grant_m, sel_m, start_m, busy_m} !== '0) begin
      fails++;
      $display("[TB] FAIL midreset_async: got grant=%b busy=%b ack=%b, want all zero", grant_m, busy_m, ack_m);
    end
    req = '0;
    tick(); tick(); tick();
`ifdef GF2MZ_SCHED_PERF_EN
    checks++;
    if (perf_ops !== '0 || perf_busy_cyc !== '0) begin
      fails++;
      $display("[TB] FAIL midreset_perf: got ops=%0d busy_cyc=%0d, want 0 0", perf_ops, perf_busy_cyc);
    end
`endif
    rst_b = 1'b1;
    req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      want_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      e.ack = want_g; e.err = 1'b0; exp_q.push_back(e);
      wait_start(6, seen);
      checks++;
      if (!seen || grant !== want_g) begin
        fails++;
        $display("[TB] FAIL rearb_grant%0d: got grant=%b, want %b", n, grant, want_g);
      end
      finish_op(5, 1'b1, 20, got);
      check_pop("rearb_ack", got);
      tick();
      req = 2'b11;
    end
    req = '0;
`ifdef GF2MZ_SCHED_PERF_EN
    checks++;
    if (perf_ops !== 16'd4 || perf_busy_cyc !== 16'd24) begin
      fails++;
      $display("[TB] FAIL perf_counts: got ops=%0d busy_cyc=%0d, want 4 24", perf_ops, perf_busy_cyc);
    end
`endif
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete, want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_spurious_done();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gf2mz_mult_sched.md
Name: gf2mz_mult_sched

Overview:
- Round-robin scheduler that shares one GF(2^m)[z] polynomial multiplier core (gf2mz_top) among NREQ requesters in the ROLLO-II decrypt datapath, e.g. the syndrome stage and the decoder stage.
- Grants one requester at a time and drives core_sel, which steers the operand and result memory muxes.
- Issues a single-cycle start to the core, waits for its done pulse, and returns a per-requester ack.
- A watchdog aborts operations that hang.

Parameters:
- NREQ, 2, number of requesters (2..8).
- SEL_W, 1, width of core_sel; must equal ceil(log2(NREQ)), minimum 1.
- TIMEOUT, 4096, maximum WAIT cycles before abort; 0 disables the watchdog.
- CNT_W, 16, width of the watchdog and performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_b  in  1  asynchronous active-low reset.
- req  in  NREQ  level request per requester; held until that requester's ack.
- ack  out  NREQ  one-cycle pulse, one-hot; the granted operation has finished.
- err  out  1  one-cycle pulse coincident with ack when the operation was aborted by timeout.
- grant  out  NREQ  one-hot; held from START through ACK.
- core_sel  out  SEL_W  binary index of the granted requester; valid while grant is nonzero.
- core_start  out  1  one-cycle start pulse to the multiplier core.
- core_done  in  1  one-cycle completion pulse from the core.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_b=0):
  - state=IDLE.
  - ack, err, grant, core_sel, core_start and busy all 0.
  - Watchdog counter 0.
  - Round-robin pointer last=NREQ-1, so req[0] has top priority after reset.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, ACK.
- IDLE:
  - If any req bit is set at edge k, select the first set bit searching from (last+1) mod NREQ upward with wrap.
  - At k+1: state=START, grant=onehot(idx), core_sel=idx, core_start=1, busy=1, last=idx.
- START:
  - Lasts exactly one cycle, then WAIT.
  - core_start=0 from k+2 onward.
  - core_done sampled high in START is ignored (spurious).
- WAIT:
  - Watchdog counter increments each cycle.
  - core_done high at edge j: at j+1 state=ACK, ack[idx]=1, err=0.
  - Counter reaching TIMEOUT-1 without core_done (TIMEOUT≠0): at the next edge state=ACK, ack[idx]=1, err=1.
  - core_done and timeout in the same cycle: core_done wins, err=0.
- ACK:
  - Lasts one cycle.
  - At the next edge: grant=0, ack=0, err=0, busy=0, counter cleared, state=IDLE.
- Requester handshake:
  - Requesters drop req on the cycle they see ack.
  - A req still high when IDLE is reentered is re-arbitrated normally. Because the pointer has advanced, other pending requesters win first.
- core_done in IDLE or ACK is ignored.
- Changes to req during START, WAIT or ACK have no effect on the current grant.
- Minimum turnaround: back-to-back operations have one IDLE cycle between ACK and the next START.
- A req bit is never acked unless it was granted.
- Reset mid-operation returns immediately to the reset state. The core is reset by the same rst_b; no ack is issued.

Optional Feature:
- Macro: GF2MZ_SCHED_PERF_EN.
- When defined, two extra output ports are added:
  - perf_ops [CNT_W-1:0]: increments on every ack.
  - perf_busy_cyc [CNT_W-1:0]: increments every cycle busy=1.
- Both counters saturate at all-ones and reset to 0.
- When undefined, neither the ports nor the counter logic exist, and the remaining behaviour is identical.

Test Plan:
- Single request: req=2'b01 at cycle 0; core_done pulsed 20 cycles after core_start → grant=01 and core_sel=0 at cycle 1; one core_start pulse at cycle 1; ack=01 the cycle after core_done; grant=0 one cycle later; err=0.
- Contention: req=2'b11 held from reset, each requester drops req on its ack → grants in order 01, 10, 01, 10; exactly one core_start per grant; never two grant bits set together.
- Fairness after reset: only req[1] asserted, then both asserted together → req[1] is granted first; of the two simultaneous requests, req[0] is granted first.
- Timeout: TIMEOUT=8 and core_done never asserted → ack and err both 1 exactly 8 cycles after entering WAIT; state back in IDLE next cycle.
- Spurious and simultaneous done: core_done pulsed in START and in IDLE → ignored. core_done coincident with the last watchdog cycle → err=0.
- Reset mid-WAIT: rst_b low for 3 cycles, then requests re-issued → all outputs 0 immediately; req[0] wins re-arbitration. With GF2MZ_SCHED_PERF_EN defined, perf_ops=0 after reset, then perf_ops=4 after four completed ops.
